// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared IDs, default widths and grant helper for mem_port_arbiter
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // Owner tag stored per accepted transaction
    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_id_e;

    // Winner when both requesters ask and no lock is held
    function automatic req_id_e arb_pick(input req_id_e last_grant, input bit rr_en);
        if (rr_en && (last_grant == REQ_DATA)) begin
            return REQ_INST;
        end
        return REQ_DATA;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - upstream inst/data channels and downstream memory port bundle
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_addr_ok;
    logic                  inst_data_ok;
    logic [DATA_W-1:0]     inst_rdata;

    logic                  data_req;
    logic                  data_wr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    logic                  mem_req;
    logic                  mem_wr;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;

    // Arbiter side
    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    // Requesters plus memory side
    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_id_fifo.sv
// rtl/mem_port_arbiter_id_fifo.sv - in-order owner-ID queue (module arb_id_fifo), 1-bit entries
module arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic             push_id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A pop frees the slot the push needs, so push is allowed when full if popping
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - inst/data to single memory port arbiter; ARB_RR_EN selects round-robin grant
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(MAX_OUT);
    localparam int CNT_W  = PTR_W + 1;

`ifdef ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        lock_vld_q, lock_vld_d;
    req_id_e     lock_id_q, lock_id_d;
    req_id_e     last_grant_q, last_grant_d;

    logic        grant_vld;
    req_id_e     grant_id;
    logic        grant_req;
    logic        accept;
    logic        resp;

    logic              fifo_full, fifo_empty, fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    logic              mux_wr;
    logic [STRB_W-1:0] mux_wstrb;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;

    // Grant selection: lock first, then priority or round-robin; nothing while full or in reset
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = REQ_INST;
        if (resetn && !fifo_full) begin
            if (lock_vld_q) begin
                grant_vld = 1'b1;
                grant_id  = lock_id_q;
            end else if (bus.inst_req && bus.data_req) begin
                grant_vld = 1'b1;
                grant_id  = arb_pick(last_grant_q, RR_EN);
            end else if (bus.data_req) begin
                grant_vld = 1'b1;
                grant_id  = REQ_DATA;
            end else if (bus.inst_req) begin
                grant_vld = 1'b1;
                grant_id  = REQ_INST;
            end
        end
    end

    // Payload mux; fetch is always a read with no strobes
    always_comb begin
        grant_req = bus.inst_req;
        mux_wr    = 1'b0;
        mux_wstrb = '0;
        mux_addr  = bus.inst_addr;
        mux_wdata = bus.data_wdata;
        if (grant_id == REQ_DATA) begin
            grant_req = bus.data_req;
            mux_wr    = bus.data_wr;
            mux_wstrb = bus.data_wstrb;
            mux_addr  = bus.data_addr;
        end
    end

    assign bus.mem_req   = grant_vld && (lock_vld_q || grant_req);
    assign bus.mem_wr    = mux_wr;
    assign bus.mem_wstrb = mux_wstrb;
    assign bus.mem_addr  = mux_addr;
    assign bus.mem_wdata = mux_wdata;

    assign accept            = bus.mem_req && bus.mem_addr_ok;
    assign bus.inst_addr_ok  = accept && (grant_id == REQ_INST);
    assign bus.data_addr_ok  = accept && (grant_id == REQ_DATA);

    // Responses on an empty queue are dropped rather than routed
    assign resp              = resetn && bus.mem_data_ok && !fifo_empty;
    assign bus.inst_data_ok  = resp && (fifo_head == REQ_INST);
    assign bus.data_data_ok  = resp && (fifo_head == REQ_DATA);
    assign bus.inst_rdata    = bus.mem_rdata;
    assign bus.data_rdata    = bus.mem_rdata;

    // Lock and last-grant next state
    always_comb begin
        lock_vld_d   = lock_vld_q;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        if (bus.mem_req && !bus.mem_addr_ok) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant_id;
        end else if (accept) begin
            lock_vld_d   = 1'b0;
            last_grant_d = grant_id;
        end
    end

    // Lock and last-grant registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_vld_q   <= 1'b0;
            lock_id_q    <= REQ_INST;
            last_grant_q <= REQ_INST;
        end else begin
            lock_vld_q   <= lock_vld_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push_i    (accept),
        .push_id_i (grant_id),
        .pop_i     (resp),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head),
        .count_o   (fifo_count)
    );

`ifndef SYNTHESIS
    // Responses still owed when reset hit may arrive afterwards; excuse that many
    logic [CNT_W-1:0] stray_budget_q;

    // Track how many post-reset strays are legitimate
    always_ff @(posedge clk) begin
        if (!resetn) begin
            if (fifo_count > stray_budget_q) begin
                stray_budget_q <= fifo_count;
            end
        end else if (bus.mem_data_ok && fifo_empty && (stray_budget_q != '0)) begin
            stray_budget_q <= stray_budget_q - CNT_W'(1);
        end
    end

    // A response with nothing outstanding is a downstream protocol error
    always_ff @(posedge clk) begin
        if (resetn && bus.mem_data_ok && fifo_empty) begin
            assert (stray_budget_q != '0)
                else $error("mem_port_arbiter: mem_data_ok with empty ID queue");
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_OUT (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    wire [4:0] hs = {bus.mem_req, bus.inst_addr_ok, bus.data_addr_ok,
                     bus.inst_data_ok, bus.data_data_ok};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = '0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_wstrb  = '0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic test_reset();
        step();
        resetn = 1'b0;
        bus.inst_req = 1'b1; bus.data_req = 1'b1;
        bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b00000) begin
            n_fail++; $display("FAIL reset_hs: got %b want 00000", hs);
        end
        step();
        #1;
        n_tests++;
        if (hs !== 5'b00000) begin
            n_fail++; $display("FAIL reset_hs2: got %b want 00000", hs);
        end
        step();
        idle();
        resetn = 1'b1;
    endtask

    task automatic test_inst_read();
        step(); idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000000; bus.mem_addr_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b11000 || bus.mem_addr !== 32'h1c000000 || {bus.mem_wr, bus.mem_wstrb} !== 5'b0) begin
            n_fail++; $display("FAIL inst_rd_c0: hs %b addr %h wr/strb %b want 11000 1c000000 00000", hs, bus.mem_addr, {bus.mem_wr, bus.mem_wstrb});
        end
        step(); idle();
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h02800405;
        #1;
        n_tests++;
        if (hs !== 5'b00010 || bus.inst_rdata !== 32'h02800405) begin
            n_fail++; $display("FAIL inst_rd_c1: hs %b rdata %h want 00010 02800405", hs, bus.inst_rdata);
        end
        step(); idle();
    endtask

    task automatic test_priority();
        step(); idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000004;
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b0011;
        bus.data_addr = 32'h00001000; bus.data_wdata = 32'hdeadbeef;
        bus.mem_addr_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b10100 || {bus.mem_wr, bus.mem_wstrb} !== 5'b10011 ||
            bus.mem_addr !== 32'h00001000 || bus.mem_wdata !== 32'hdeadbeef) begin
            n_fail++; $display("FAIL prio_data_first: hs %b wr/strb %b addr %h wdata %h want 10100 10011 00001000 deadbeef", hs, {bus.mem_wr, bus.mem_wstrb}, bus.mem_addr, bus.mem_wdata);
        end
        step();
        bus.data_req = 1'b0;
        #1;
        n_tests++;
        if (hs !== 5'b11000 || bus.mem_addr !== 32'h1c000004 || {bus.mem_wr, bus.mem_wstrb} !== 5'b0) begin
            n_fail++; $display("FAIL prio_inst_next: hs %b addr %h wr/strb %b want 11000 1c000004 00000", hs, bus.mem_addr, {bus.mem_wr, bus.mem_wstrb});
        end
        step();
        bus.inst_req = 1'b0; bus.mem_data_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b00001) begin
            n_fail++; $display("FAIL prio_write_resp: hs %b want 00001", hs);
        end
        step();
        #1;
        n_tests++;
        if (hs !== 5'b00010) begin
            n_fail++; $display("FAIL prio_inst_resp: hs %b want 00010", hs);
        end
        step(); idle();
    endtask

    task automatic test_arbitration();
        logic [4:0] exp_c1, exp_c2;
`ifdef ARB_RR_EN
        exp_c1 = 5'b11001;
        exp_c2 = 5'b10110;
`else
        exp_c1 = 5'b10101;
        exp_c2 = 5'b10101;
`endif
        step(); idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000008;
        bus.data_req = 1'b1; bus.data_addr = 32'h00001004;
        bus.mem_addr_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b10100) begin
            n_fail++; $display("FAIL arb_c0: hs %b want 10100", hs);
        end
        step();
        bus.mem_data_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== exp_c1) begin
            n_fail++; $display("FAIL arb_c1: hs %b want %b", hs, exp_c1);
        end
        step();
        #1;
        n_tests++;
        if (hs !== exp_c2) begin
            n_fail++; $display("FAIL arb_c2: hs %b want %b", hs, exp_c2);
        end
        step();
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        #1;
        n_tests++;
        if (hs !== 5'b00001) begin
            n_fail++; $display("FAIL arb_drain: hs %b want 00001", hs);
        end
        step(); idle();
    endtask

    task automatic test_lock();
        step(); idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000010;
        #1;
        n_tests++;
        if (hs !== 5'b10000 || bus.mem_addr !== 32'h1c000010) begin
            n_fail++; $display("FAIL lock_c0: hs %b addr %h want 10000 1c000010", hs, bus.mem_addr);
        end
        step();
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b1111;
        bus.data_addr = 32'h00002000; bus.data_wdata = 32'h00000055;
        for (int c = 1; c < 3; c++) begin
            #1;
            n_tests++;
            if (hs !== 5'b10000 || bus.mem_addr !== 32'h1c000010 || bus.mem_wr !== 1'b0) begin
                n_fail++; $display("FAIL lock_hold_c%0d: hs %b addr %h wr %b want 10000 1c000010 0", c, hs, bus.mem_addr, bus.mem_wr);
            end
            step();
        end
        bus.mem_addr_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b11000 || bus.mem_addr !== 32'h1c000010) begin
            n_fail++; $display("FAIL lock_release: hs %b addr %h want 11000 1c000010", hs, bus.mem_addr);
        end
        step();
        bus.inst_req = 1'b0;
        #1;
        n_tests++;
        if (hs !== 5'b10100 || bus.mem_addr !== 32'h00002000 || bus.mem_wr !== 1'b1) begin
            n_fail++; $display("FAIL lock_data_after: hs %b addr %h wr %b want 10100 00002000 1", hs, bus.mem_addr, bus.mem_wr);
        end
        step();
        bus.data_req = 1'b0; bus.mem_data_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b00010) begin
            n_fail++; $display("FAIL lock_resp_inst: hs %b want 00010", hs);
        end
        step();
        #1;
        n_tests++;
        if (hs !== 5'b00001) begin
            n_fail++; $display("FAIL lock_resp_data: hs %b want 00001", hs);
        end
        step(); idle();
    endtask

    task automatic test_full();
        step(); idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000020; bus.mem_addr_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b11000) begin
            n_fail++; $display("FAIL full_c0: hs %b want 11000", hs);
        end
        step();
        bus.inst_req = 1'b0; bus.data_req = 1'b1; bus.data_addr = 32'h00003000;
        #1;
        n_tests++;
        if (hs !== 5'b10100) begin
            n_fail++; $display("FAIL full_c1: hs %b want 10100", hs);
        end
        step();
        bus.data_req = 1'b0; bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000024;
        #1;
        n_tests++;
        if (hs !== 5'b00000) begin
            n_fail++; $display("FAIL full_blocked: hs %b want 00000", hs);
        end
        step();
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h11111111;
        #1;
        n_tests++;
        if (hs !== 5'b00010 || bus.inst_rdata !== 32'h11111111) begin
            n_fail++; $display("FAIL full_pop_blocked: hs %b rdata %h want 00010 11111111", hs, bus.inst_rdata);
        end
        step();
        bus.mem_rdata = 32'h22222222;
        #1;
        n_tests++;
        if (hs !== 5'b11001 || bus.data_rdata !== 32'h22222222 || bus.mem_addr !== 32'h1c000024) begin
            n_fail++; $display("FAIL full_third_issue: hs %b rdata %h addr %h want 11001 22222222 1c000024", hs, bus.data_rdata, bus.mem_addr);
        end
        step();
        bus.inst_req = 1'b0; bus.mem_rdata = 32'h33333333;
        #1;
        n_tests++;
        if (hs !== 5'b00010 || bus.inst_rdata !== 32'h33333333) begin
            n_fail++; $display("FAIL full_third_resp: hs %b rdata %h want 00010 33333333", hs, bus.inst_rdata);
        end
        step(); idle();
    endtask

    task automatic test_push_pop();
        step(); idle();
        bus.data_req = 1'b1; bus.data_addr = 32'h00004000; bus.mem_addr_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b10100) begin
            n_fail++; $display("FAIL pp_c0: hs %b want 10100", hs);
        end
        step();
        bus.data_req = 1'b0; bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000030;
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'haaaa5555;
        #1;
        n_tests++;
        if (hs !== 5'b11001 || bus.data_rdata !== 32'haaaa5555) begin
            n_fail++; $display("FAIL pp_same_cycle: hs %b rdata %h want 11001 aaaa5555", hs, bus.data_rdata);
        end
        step();
        bus.inst_req = 1'b0;
        #1;
        n_tests++;
        if (hs !== 5'b00010) begin
            n_fail++; $display("FAIL pp_second_resp: hs %b want 00010", hs);
        end
        step(); idle();
    endtask

    task automatic test_reset_flush();
        step(); idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000040; bus.mem_addr_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b11000) begin
            n_fail++; $display("FAIL flush_c0: hs %b want 11000", hs);
        end
        step();
        bus.inst_req = 1'b0; bus.data_req = 1'b1; bus.data_addr = 32'h00005000;
        #1;
        n_tests++;
        if (hs !== 5'b10100) begin
            n_fail++; $display("FAIL flush_c1: hs %b want 10100", hs);
        end
        step();
        bus.data_req = 1'b0; bus.inst_req = 1'b1; resetn = 1'b0;
        #1;
        n_tests++;
        if (hs !== 5'b00000) begin
            n_fail++; $display("FAIL flush_in_reset: hs %b want 00000", hs);
        end
        step();
        resetn = 1'b1; idle();
        bus.mem_data_ok = 1'b1;
        for (int s = 0; s < 2; s++) begin
            #1;
            n_tests++;
            if (hs !== 5'b00000) begin
                n_fail++; $display("FAIL flush_stray%0d: hs %b want 00000", s, hs);
            end
            step();
        end
        idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000044; bus.mem_addr_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b11000) begin
            n_fail++; $display("FAIL flush_recover: hs %b want 11000", hs);
        end
        step();
        bus.inst_req = 1'b0; bus.mem_data_ok = 1'b1;
        #1;
        n_tests++;
        if (hs !== 5'b00010) begin
            n_fail++; $display("FAIL flush_recover_resp: hs %b want 00010", hs);
        end
        step(); idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        resetn  = 1'b0;
        idle();
        test_reset();
        test_inst_read();
        test_priority();
        test_arbitration();
        test_lock();
        test_full();
        test_push_pop();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one SRAM-like memory port between the fetch-side instruction requester and the EXE-stage data requester, which drives enable, byte-write strobes, address and write data. Each upstream channel uses the req/addr_ok/data_ok handshake. The arbiter grants one request per cycle and locks the grant until the memory accepts it. It records the owner of every accepted transaction in an in-order ID queue and routes each response back to its owner. It sits between the pipeline front/EXE stages and the memory bridge, and adds no latency.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- MAX_OUT, 2, maximum accepted-but-unanswered transactions; power of 2, ≥2
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- inst_req / inst_addr  in  1 / ADDR_W  instruction read request and address
- inst_addr_ok / inst_data_ok  out  1 / 1  instruction request accepted / response valid
- inst_rdata  out  DATA_W  instruction read data
- data_req / data_wr  in  1 / 1  data request; 1 = write
- data_wstrb / data_addr / data_wdata  in  DATA_W/8 / ADDR_W / DATA_W  write byte strobes, address, write data
- data_addr_ok / data_data_ok  out  1 / 1  data request accepted / response valid
- data_rdata  out  DATA_W  data read data
- mem_req / mem_wr / mem_wstrb / mem_addr / mem_wdata  out  1 / 1 / DATA_W/8 / ADDR_W / DATA_W  downstream request
- mem_addr_ok / mem_data_ok  in  1 / 1  downstream accept / response
- mem_rdata  in  DATA_W  downstream read data

## Operation
- **State:** lock_vld, lock_id (0 = inst, 1 = data), last_grant, ID queue (MAX_OUT entries of 1 bit each) with occupancy count.
- **Grant:**
  - If lock_vld, grant = lock_id.
  - Otherwise, data wins over inst when both request.
  - No grant when the queue is full (count == MAX_OUT).
- **Request path:**
  - mem_req = granted requester's req (or 1 if locked).
  - mem_wr, mem_wstrb, mem_addr and mem_wdata are muxed from the granted requester. The inst path forces wr = 0 and wstrb = 0.
- **Lock:**
  - Set when mem_req && !mem_addr_ok; lock_id = current grant.
  - Cleared on mem_req && mem_addr_ok.
  - While locked, the other requester is never granted, even if it has higher priority.
- **Accept:** on mem_req && mem_addr_ok:
  - assert addr_ok to the granted requester only;
  - push the grant ID into the queue;
  - update last_grant.
- **Response:** on mem_data_ok with count > 0:
  - pop the head;
  - assert the head owner's data_ok for that cycle;
  - drive mem_rdata onto that owner's rdata.
  - Writes also receive exactly one data_ok.
  - rdata is don't-care for the non-owner; drive mem_rdata to both.
- **Push and pop in the same cycle:** count unchanged. Issue is still blocked if count was MAX_OUT at the start of the cycle; there is no mem_data_ok→mem_req path.
- **mem_data_ok with empty queue:** protocol error. Ignored, with no data_ok output; flagged by an assertion in simulation.
- **Upstream protocol:** a requester holds req and payload stable until its addr_ok. The arbiter does not check this.
- **Reset (resetn = 0 at a clk edge):**
  - count = 0, queue pointers = 0, lock_vld = 0, last_grant = inst.
  - While resetn is low, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are forced to 0.
  - In-flight responses arriving after reset hit an empty queue and are dropped.

## Timing
- Grant, mem_req, addr_ok and data_ok are combinational; arbitration adds zero cycles.
- Best-case back-to-back throughput: one accept per cycle until MAX_OUT are outstanding.
- A response may coincide with acceptance of a new request in the same cycle.
- The oldest outstanding transaction is always answered first. Ordering across requesters is preserved by the queue.
- The lock holds for as many cycles as mem_addr_ok stays low. The grant never changes while locked.

## Configuration
- **ARB_RR_EN defined:** when both request and not locked, grant the requester other than last_grant (round-robin). A stream of data requests cannot starve fetch.
- **ARB_RR_EN undefined:** fixed priority, data over inst. last_grant still exists but does not affect the grant.

## Structure
- Shared package (mem_arb_pkg):
  - ID encodings REQ_INST = 1'b0 and REQ_DATA = 1'b1;
  - default widths ADDR_W / DATA_W.
- Sub-module arb_id_fifo:
  - parameterised depth MAX_OUT, 1-bit entries;
  - push/pop/full/empty/head;
  - synchronous active-low reset;
  - simultaneous push/pop supported, including when full.

## Test plan
- inst_req = 1 @0x1c000000, mem_addr_ok = 1, mem_data_ok 1 cycle later with rdata 0x02800405 -> inst_addr_ok in cycle 0; inst_data_ok and inst_rdata = 0x02800405 in cycle 1; data_* stays 0.
- inst and data both request; data is a write, wstrb 4'b0011, addr 0x1000, wdata 0xdeadbeef; mem_addr_ok = 1 -> data accepted first with mem_wstrb = 0011; inst accepted the next cycle. Repeat with ARB_RR_EN -> grants alternate.
- mem_addr_ok held low 3 cycles on an inst request; data_req rises in cycle 1 -> mem_addr stays the inst address for all 3 cycles; data granted only after inst_addr_ok.
- MAX_OUT = 2: two accepted reads with no response, third request present -> mem_req = 0. Then mem_data_ok -> responses are returned in order, and the third request issues the cycle after the first pop.
- Push and pop in the same cycle at count 1 -> count remains 1, and the response routes to the older owner.
- resetn low for 1 cycle with 2 outstanding, then 2 stray mem_data_ok pulses -> no data_ok on either channel, and mem_req = 0 during reset.
